// File: rtl/cache_mem_responder.sv
// Main-memory responder for cache block fills and dirty write-backs.
// Block-addressed store with fixed read/write latency and busy/ack handshake.
module cache_mem_responder #(
  parameter int PA_WIDTH   = 32,
  parameter int BLK_WIDTH  = 512,
  parameter int MEM_BLOCKS = 1024,
  parameter int RD_LAT     = 4,
  parameter int WR_LAT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PA_WIDTH-1:0]  mem_addr,
  input  logic [PA_WIDTH-1:0]  mem_wb_addr,
  input  logic                 mem_rd_en,
  input  logic                 mem_wr_en,
  input  logic [BLK_WIDTH-1:0] mem_wr_blk,
  output logic [BLK_WIDTH-1:0] mem_rd_blk,
  output logic                 mem_busy,
  output logic                 mem_ack
);

  localparam int IW = $clog2(MEM_BLOCKS);
  localparam int ML = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW = $clog2(ML + 1);
  localparam logic [CW-1:0] WR_END = CW'(WR_LAT - 1);
  localparam logic [CW-1:0] RD_END = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        rd_idx;
  logic [IW-1:0]        wr_idx;
  logic [BLK_WIDTH-1:0] wr_blk;
  logic                 pend_rd;
  logic                 wr_commit;

  logic [BLK_WIDTH-1:0] store [MEM_BLOCKS] = '{default: '0};

  // Offset and alias bits above the index carry no information here.
  logic unused_bits;
  assign unused_bits = ^{mem_addr[5:0],
                         mem_addr[PA_WIDTH-1:6+IW],
                         mem_wb_addr[5:0],
                         mem_wb_addr[PA_WIDTH-1:6+IW]};

  assign wr_commit = (state == WRITE) && (cnt == WR_END);

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      store[wr_idx] <= wr_blk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_busy   <= 1'b0;
      mem_ack    <= 1'b0;
      mem_rd_blk <= '0;
      pend_rd    <= 1'b0;
      rd_idx     <= '0;
      wr_idx     <= '0;
      wr_blk     <= '0;
    end else begin
      mem_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (mem_wr_en) begin
            wr_idx   <= mem_wb_addr[6 +: IW];
            wr_blk   <= mem_wr_blk;
            rd_idx   <= mem_addr[6 +: IW];
            pend_rd  <= mem_rd_en;
            mem_busy <= 1'b1;
            state    <= WRITE;
          end else if (mem_rd_en) begin
            rd_idx   <= mem_addr[6 +: IW];
            pend_rd  <= 1'b0;
            mem_busy <= 1'b1;
            state    <= READ;
          end
        end
        WRITE: begin
          if (cnt == WR_END) begin
            cnt     <= '0;
            pend_rd <= 1'b0;
            if (pend_rd) begin
              state <= READ;
            end else begin
              mem_busy <= 1'b0;
              mem_ack  <= 1'b1;
              state    <= RESP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          if (cnt == RD_END) begin
            cnt        <= '0;
            mem_rd_blk <= store[rd_idx];
            mem_busy   <= 1'b0;
            mem_ack    <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
